// File: rtl/led_anim_pkg.sv
// Shared encodings for the LED animator: mode select values and per-animation phase enums.
package led_anim_pkg;

  localparam logic [1:0] MODE_CHASE      = 2'd0;
  localparam logic [1:0] MODE_FILL_DRAIN = 2'd1;
  localparam logic [1:0] MODE_BREATHE    = 2'd2;
  localparam logic [1:0] MODE_COMET      = 2'd3;

  // FILL_DRAIN animation phase
  typedef enum logic {
    PhaseFill,
    PhaseDrain
  } fill_phase_e;

  // BREATHE animation phase
  typedef enum logic {
    RampUp,
    RampDown
  } ramp_phase_e;

endpackage

// File: rtl/led_step_timer.sv
// Animation step prescaler: emits a one-cycle tick every max(load,1) cycles.
module led_step_timer #(
  parameter int unsigned STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              hold,
  input  logic [STEP_W-1:0] load,
  output logic              tick
);

  logic [STEP_W-1:0] cnt_q;
  logic [STEP_W-1:0] last;

  // Terminal count; a count already past a newly lowered limit ticks at once and wraps.
  always_comb begin
    last = (load == '0) ? '0 : load - STEP_W'(1);
    tick = !clr && !hold && (cnt_q >= last);
  end

  // Count register: cleared by reset or clr, frozen by hold, wraps on tick.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= tick ? '0 : cnt_q + STEP_W'(1);
    end
  end

endmodule

// File: rtl/led_animator.sv
// LED animator: CHASE, FILL_DRAIN, BREATHE and COMET patterns with a registered LED stage.
module led_animator
  import led_anim_pkg::*;
#(
  parameter int unsigned N_LED  = 8,
  parameter int unsigned STEP_W = 16,
  parameter int unsigned PWM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              enable,
  input  logic [STEP_W-1:0] step_load,
  output logic [N_LED-1:0]  led_out,
  output logic              frame_done
);

  localparam int unsigned POS_W = $clog2(N_LED);
  localparam logic [POS_W-1:0] LAST = POS_W'(N_LED - 1);
  localparam logic [PWM_W-1:0] DMAX = '1;
  localparam logic [PWM_W-1:0] DMAX_M1 = DMAX - PWM_W'(1);
  localparam logic [PWM_W-1:0] DMAX_HALF = DMAX >> 1;
  localparam logic [PWM_W-1:0] DMAX_QTR = DMAX >> 2;

  logic [1:0]       mode_q;
  logic [PWM_W-1:0] pwm_q;
  logic [POS_W-1:0] pos_q, pos_d, pos_dec;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [N_LED-1:0] bar_q, bar_d;
  fill_phase_e      fill_q, fill_d;
  ramp_phase_e      ramp_q, ramp_d;
  logic             wrap_q, wrap_d;
  logic [N_LED-1:0] led_d;
  logic [N_LED+1:0] comet_v;
  logic             mode_chg;
  logic             tick;

  assign mode_chg = (mode != mode_q);

  led_step_timer #(
    .STEP_W(STEP_W)
  ) u_step_timer (
    .clk (clk),
    .rst (rst),
    .clr (mode_chg),
    .hold(!enable),
    .load(step_load),
    .tick(tick)
  );

  // Next animation state on a step tick; wrap_d flags the tick that ends a frame.
  always_comb begin
    pos_d   = pos_q;
    duty_d  = duty_q;
    bar_d   = bar_q;
    fill_d  = fill_q;
    ramp_d  = ramp_q;
    wrap_d  = 1'b0;
    pos_dec = (pos_q == '0) ? LAST : pos_q - POS_W'(1);
    if (tick) begin
      unique case (mode_q)
        MODE_CHASE, MODE_COMET: begin
          pos_d  = pos_dec;
          wrap_d = (pos_q == '0);
        end
        MODE_FILL_DRAIN: begin
          if (fill_q == PhaseFill) begin
            bar_d = {1'b1, bar_q[N_LED-1:1]};
            // bar fills contiguously from the MSB, so bit 1 set means this shift completes it
            if (bar_q[1]) fill_d = PhaseDrain;
          end else begin
            bar_d = {1'b0, bar_q[N_LED-1:1]};
            if (bar_q[N_LED-1:1] == '0) begin
              fill_d = PhaseFill;
              wrap_d = 1'b1;
            end
          end
        end
        MODE_BREATHE: begin
          if (ramp_q == RampUp) begin
            if (duty_q != DMAX) duty_d = duty_q + PWM_W'(1);
            if (duty_q >= DMAX_M1) ramp_d = RampDown;
          end else begin
            if (duty_q != '0) duty_d = duty_q - PWM_W'(1);
            if (duty_q <= PWM_W'(1)) begin
              ramp_d = RampUp;
              pos_d  = pos_dec;
              wrap_d = (pos_q == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // LED pattern rendered from the current state and PWM phase.
  always_comb begin
    led_d   = '0;
    comet_v = (N_LED + 2)'({pwm_q < DMAX_QTR, pwm_q < DMAX_HALF, pwm_q < DMAX}) << pos_q;
    unique case (mode_q)
      MODE_CHASE:      led_d = N_LED'(1'b1) << pos_q;
      MODE_FILL_DRAIN: led_d = bar_q;
      MODE_BREATHE:    led_d = N_LED'(pwm_q < duty_q) << pos_q;
      MODE_COMET:      led_d = comet_v[N_LED-1:0];  // tail bits past the MSB fall off here
      default:         led_d = '0;
    endcase
  end

  // State and output registers; reset beats mode change, which beats enable.
  always_ff @(posedge clk) begin
    if (rst || mode_chg) begin
      mode_q     <= mode;
      pwm_q      <= '0;
      pos_q      <= LAST;
      duty_q     <= '0;
      bar_q      <= '0;
      fill_q     <= PhaseFill;
      ramp_q     <= RampUp;
      wrap_q     <= 1'b0;
      led_out    <= '0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      led_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      pwm_q      <= (pwm_q == DMAX_M1) ? '0 : pwm_q + PWM_W'(1);
      pos_q      <= pos_d;
      duty_q     <= duty_d;
      bar_q      <= bar_d;
      fill_q     <= fill_d;
      ramp_q     <= ramp_d;
      wrap_q     <= wrap_d;
      led_out    <= led_d;
      frame_done <= wrap_q;  // lands with the first LED value of the new frame
    end
  end

endmodule

// File: tb/tb_led_animator.sv
// Self-checking bench for led_animator against a step-index based reference model.
module tb_led_animator;

  localparam int N  = 8;
  localparam int SW = 16;
  localparam int PW = 4;
  localparam int D  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          enable;
  logic [SW-1:0] step_load;
  logic [N-1:0]  led_out;
  logic          frame_done;

  always #5 clk = ~clk;

  led_animator #(
    .N_LED (N),
    .STEP_W(SW),
    .PWM_W (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .enable    (enable),
    .step_load (step_load),
    .led_out   (led_out),
    .frame_done(frame_done)
  );

  int       errors = 0;
  int       checks = 0;
  string    tag = "init";

  // Reference model: prescaler count, PWM phase, step index within the frame.
  int       m_mode = -1;
  int       m_cnt, m_pwm, m_step;
  bit       m_pend;
  logic [N-1:0] exp_led;
  logic     exp_fd;

  function automatic int frame_len(int md);
    case (md)
      0, 3:    return N;
      1:       return 2 * N;
      default: return 2 * D * N;
    endcase
  endfunction

  function automatic logic [N-1:0] render(int md, int s, int pwm);
    logic [N-1:0] v;
    int k, d, idx;
    v = '0;
    case (md)
      0: v[N-1-s] = 1'b1;
      1: for (int b = 0; b < N; b++) v[b] = (s <= N) ? (b >= N - s) : (b < 2 * N - s);
      2: begin
        k = s % (2 * D);
        d = (k <= D) ? k : 2 * D - k;
        v[N-1-s/(2*D)] = (pwm < d);
      end
      default: for (int j = 0; j < 3; j++) begin
        idx = N - 1 - s + j;
        if (idx < N) v[idx] = (pwm < (D >> j));
      end
    endcase
    return v;
  endfunction

  task automatic model_clear();
    m_mode  = int'(mode);
    m_cnt   = 0;
    m_pwm   = 0;
    m_step  = 0;
    m_pend  = 0;
    exp_led = '0;
    exp_fd  = 1'b0;
  endtask

  task automatic cycle();
    int  mx;
    bit  tk;
    @(posedge clk);
    if (rst || int'(mode) != m_mode) begin
      model_clear();
    end else if (!enable) begin
      exp_led = '0;
      exp_fd  = 1'b0;
    end else begin
      exp_led = render(m_mode, m_step, m_pwm);
      exp_fd  = m_pend;
      m_pend  = 0;
      mx      = (step_load == 0) ? 1 : int'(step_load);
      tk      = (m_cnt >= mx - 1);
      m_cnt   = tk ? 0 : m_cnt + 1;
      m_pwm   = (m_pwm + 1) % D;
      if (tk) begin
        m_step++;
        if (m_step == frame_len(m_mode)) begin
          m_step = 0;
          m_pend = 1;
        end
      end
    end
    #1;
    checks++;
    assert (led_out === exp_led) else begin
      errors++;
      $error("FAIL %s led_out got %h want %h", tag, led_out, exp_led);
    end
    checks++;
    assert (frame_done === exp_fd) else begin
      errors++;
      $error("FAIL %s frame_done got %b want %b", tag, frame_done, exp_fd);
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int guard;
    rst       = 1'b1;
    mode      = 2'd0;
    enable    = 1'b1;
    step_load = 16'd4;

    tag = "reset";
    run(3);
    rst = 1'b0;

    tag = "chase";
    run(40);

    // Freeze mid-CHASE on 0x10, then resume
    tag   = "seek_0x10";
    guard = 0;
    while (exp_led != 8'h10 && guard < 100) begin
      cycle();
      guard++;
    end
    checks++;
    assert (guard < 100) else begin
      errors++;
      $error("FAIL seek_0x10 cycles got %0d want <100", guard);
    end
    run(1);
    tag    = "frozen";
    enable = 1'b0;
    run(10);
    tag    = "resume";
    enable = 1'b1;
    run(12);
    tag       = "load0";
    step_load = 16'd0;
    run(20);

    tag       = "fill_drain";
    step_load = 16'd4;
    mode      = 2'd1;
    run(80);

    tag       = "breathe";
    step_load = 16'd1;
    mode      = 2'd2;
    run(260);

    tag       = "comet";
    step_load = 16'd2;
    mode      = 2'd3;
    run(60);

    tag = "reset_mid";
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(20);

    tag = "mode_while_off";
    enable = 1'b0;
    mode   = 2'd0;
    run(3);
    enable = 1'b1;
    run(20);

    tag = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 5) enable = ~enable;
      if ($urandom_range(0, 99) < 4) step_load = 16'($urandom_range(0, 5));
      rst = ($urandom_range(0, 999) < 3);
      cycle();
    end
    rst    = 1'b0;
    enable = 1'b1;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
